// File: rtl/m_load_unit.sv
// Memory-stage load unit: word-aligned req/gnt/rvalid fetch,
// lane select and sign/zero extension, AdEL detection.
module m_load_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_op,
  input  logic [TAG_W-1:0]  ld_tag,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_exc,
  input  logic              res_ready,
  output logic              busy
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LB  = 3'b100;
  localparam logic [2:0] OP_LBU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       data_q, data_d;
  logic              exc_q, exc_d;

  logic        in_lw, in_lh, in_load, in_misal;
  logic [31:0] word;
  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic [31:0] ext;

  assign in_lw    = (ld_op == OP_LW);
  assign in_lh    = (ld_op == OP_LH) || (ld_op == OP_LHU);
  assign in_load  = in_lw || in_lh ||
                    (ld_op == OP_LB) || (ld_op == OP_LBU);
  assign in_misal = (in_lw && (ld_addr[1:0] != 2'b00)) ||
                    (in_lh && ld_addr[0]);

  // Wide beats carry two words; addr[2] picks the lane.
  if (DATA_W == 64) begin : g_w64
    assign word = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  end else begin : g_w32
    assign word = mem_rdata[31:0];
  end

  assign half = addr_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    byte_sel = word[7:0];
    unique case (addr_q[1:0])
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  always_comb begin
    ext = '0;
    unique case (1'b1)
      (op_q == OP_LW):  ext = word;
      (op_q == OP_LH):  ext = {{16{half[15]}}, half};
      (op_q == OP_LHU): ext = {16'h0, half};
      (op_q == OP_LB):  ext = {{24{byte_sel[7]}}, byte_sel};
      (op_q == OP_LBU): ext = {24'h0, byte_sel};
      default:          ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    tag_d   = tag_q;
    data_d  = data_q;
    exc_d   = exc_q;
    unique case (state_q)
      S_IDLE: begin
        if (ld_valid) begin
          addr_d = ld_addr;
          op_d   = ld_op;
          tag_d  = ld_tag;
          unique case (1'b1)
            in_misal: begin
              data_d  = '0;
              exc_d   = 1'b1;
              state_d = S_RESP;
            end
            !in_load: begin
              data_d  = '0;
              exc_d   = 1'b0;
              state_d = S_RESP;
            end
            default: begin
              exc_d   = 1'b0;
              state_d = S_REQ;
            end
          endcase
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          data_d  = ext;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready  = (state_q == S_IDLE);
    mem_req   = (state_q == S_REQ);
    res_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
    mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    res_data  = data_q;
    res_tag   = tag_q;
    res_exc   = exc_q;
  end

endmodule

// File: tb/tb_m_load_unit.sv
// Directed bench for m_load_unit: 32- and 64-bit beat instances,
// scoreboard of expected results, immediate assertions.
module tb_m_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_op;
  logic [4:0]  ld_tag;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] rdata32;
  logic [63:0] rdata64;
  logic        res_ready;

  logic        a_ready, a_req, a_valid, a_exc, a_busy;
  logic [31:0] a_maddr, a_data;
  logic [4:0]  a_tag;
  logic        b_ready, b_req, b_valid, b_exc, b_busy;
  logic [31:0] b_maddr, b_data;
  logic [4:0]  b_tag;

  logic        sel64;
  logic        o_ready, o_req, o_valid, o_exc, o_busy;
  logic [31:0] o_maddr, o_data;
  logic [4:0]  o_tag;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  always #5 clk = ~clk;

  m_load_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(a_ready),
    .ld_addr(ld_addr), .ld_op(ld_op), .ld_tag(ld_tag),
    .mem_req(a_req), .mem_addr(a_maddr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(rdata32),
    .res_valid(a_valid), .res_data(a_data),
    .res_tag(a_tag), .res_exc(a_exc),
    .res_ready(res_ready), .busy(a_busy)
  );

  m_load_unit #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(b_ready),
    .ld_addr(ld_addr), .ld_op(ld_op), .ld_tag(ld_tag),
    .mem_req(b_req), .mem_addr(b_maddr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(rdata64),
    .res_valid(b_valid), .res_data(b_data),
    .res_tag(b_tag), .res_exc(b_exc),
    .res_ready(res_ready), .busy(b_busy)
  );

  assign o_ready = sel64 ? b_ready : a_ready;
  assign o_req   = sel64 ? b_req   : a_req;
  assign o_valid = sel64 ? b_valid : a_valid;
  assign o_exc   = sel64 ? b_exc   : a_exc;
  assign o_busy  = sel64 ? b_busy  : a_busy;
  assign o_maddr = sel64 ? b_maddr : a_maddr;
  assign o_data  = sel64 ? b_data  : a_data;
  assign o_tag   = sel64 ? b_tag   : a_tag;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d,
                      input logic [4:0] t,
                      input logic e);
    exp_t x;
    x.d = d;
    x.t = t;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic run_load(input logic [2:0]  op,
                          input logic [31:0] addr,
                          input logic [4:0]  tag,
                          input int          gdly,
                          input int          rdly,
                          input int          exp_lat,
                          input bit          exp_req,
                          input logic [31:0] exp_maddr);
    int   k;
    int   lat;
    int   reqc;
    int   held;
    bit   gprev;
    bit   done;
    exp_t ex;
    ex.d = '0;
    ex.t = '0;
    ex.e = 1'b0;
    @(negedge clk);
    chk("ld_ready_idle", o_ready, 1);
    ld_valid = 1'b1;
    ld_op    = op;
    ld_addr  = addr;
    ld_tag   = tag;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_op    = 3'b000;
    k = 1; lat = 0; reqc = 0; held = 0;
    gprev = 1'b0; done = 1'b0;
    while (!done && k <= 40) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      res_ready  = 1'b0;
      if (o_valid) begin
        if (lat == 0) begin
          lat = k;
          chk("latency", k, exp_lat);
          if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: got result, expected none");
          end else begin
            ex = sb.pop_front();
          end
        end
        chk("res_data", o_data, ex.d);
        chk("res_tag", o_tag, ex.t);
        chk("res_exc", o_exc, ex.e);
        chk("resp_busy", o_busy, 1);
        if (held == rdly) res_ready = 1'b1;
        held++;
      end else if (lat != 0) begin
        chk("idle_busy", o_busy, 0);
        chk("idle_ready", o_ready, 1);
        done = 1'b1;
      end else begin
        chk("txn_busy", o_busy, 1);
        chk("txn_ready", o_ready, 0);
        if (o_req) begin
          reqc++;
          chk("mem_addr", o_maddr, exp_maddr);
          if (reqc > gdly) mem_gnt = 1'b1;
        end
        if (gprev) mem_rvalid = 1'b1;
        gprev = mem_gnt;
      end
      if (!done) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; res_ready = 1'b0;
    if (!done) begin
      n_fail++;
      $error("FAIL timeout: got no completion, expected one");
    end
    chk("req_cycles", reqc, exp_req ? gdly + 1 : 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    sel64 = 1'b0;
    reset = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_op = '0; ld_tag = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; res_ready = 1'b0;
    rdata32 = 32'h80FF7F01;
    rdata64 = 64'h1122334455667788;
    #12;
    chk("rst_req", a_req, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_exc", a_exc, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_data", a_data, 0);
    chk("rst_tag", a_tag, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_ld_ready", a_ready, 1);

    // 32-bit beat extension cases
    push(32'hFFFFFF80, 5'd1, 1'b0);
    run_load(3'b100, 32'h103, 5'd1, 0, 0, 3, 1, 32'h100);
    push(32'h00000080, 5'd2, 1'b0);
    run_load(3'b101, 32'h103, 5'd2, 0, 0, 3, 1, 32'h100);
    push(32'hFFFF80FF, 5'd3, 1'b0);
    run_load(3'b010, 32'h102, 5'd3, 0, 0, 3, 1, 32'h100);
    push(32'h00007F01, 5'd4, 1'b0);
    run_load(3'b011, 32'h100, 5'd4, 0, 0, 3, 1, 32'h100);
    push(32'h80FF7F01, 5'd5, 1'b0);
    run_load(3'b001, 32'h100, 5'd5, 0, 0, 3, 1, 32'h100);

    // misaligned and no-op loads never touch memory
    push(32'h0, 5'd7, 1'b1);
    run_load(3'b001, 32'h102, 5'd7, 0, 0, 1, 0, 32'h0);
    push(32'h0, 5'd7, 1'b1);
    run_load(3'b010, 32'h101, 5'd7, 0, 0, 1, 0, 32'h0);
    push(32'h0, 5'd6, 1'b0);
    run_load(3'b000, 32'h100, 5'd6, 0, 0, 1, 0, 32'h0);
    push(32'h0, 5'd8, 1'b0);
    run_load(3'b110, 32'h104, 5'd8, 0, 0, 1, 0, 32'h0);

    // 64-bit beat lane selection
    sel64 = 1'b1;
    push(32'h11223344, 5'd10, 1'b0);
    run_load(3'b001, 32'h104, 5'd10, 0, 0, 3, 1, 32'h100);
    push(32'h00000077, 5'd11, 1'b0);
    run_load(3'b100, 32'h101, 5'd11, 0, 0, 3, 1, 32'h100);
    push(32'h00000011, 5'd12, 1'b0);
    run_load(3'b101, 32'h107, 5'd12, 0, 0, 3, 1, 32'h100);
    sel64 = 1'b0;

    // handshake stress: slow grant, slow consumer
    push(32'h80FF7F01, 5'd13, 1'b0);
    run_load(3'b001, 32'h100, 5'd13, 4, 0, 7, 1, 32'h100);
    push(32'hFFFFFF80, 5'd9, 1'b0);
    run_load(3'b100, 32'h103, 5'd9, 0, 3, 3, 1, 32'h100);

    // spurious rvalid while idle
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    chk("spur_valid", a_valid, 0);
    chk("spur_busy", a_busy, 0);

    // reset while waiting for read data
    @(negedge clk);
    ld_valid = 1'b1; ld_op = 3'b001;
    ld_addr = 32'h100; ld_tag = 5'd3;
    @(posedge clk);
    #1;
    ld_valid = 1'b0; ld_op = 3'b000;
    mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    chk("wait_busy", a_busy, 1);
    reset = 1'b0;
    #1;
    chk("arst_req", a_req, 0);
    chk("arst_valid", a_valid, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_tag", a_tag, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b1;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    chk("late_rvalid", a_valid, 0);
    chk("late_busy", a_busy, 0);
    push(32'h80FF7F01, 5'd14, 1'b0);
    run_load(3'b001, 32'h100, 5'd14, 0, 0, 3, 1, 32'h100);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
